// File: rtl/vga_game_if.sv
// Video-side bundle of vga_game_frontend: scan position and strobes out to the
// game logic, game colour back in, and the aligned VGA pins.
interface vga_game_if #(
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int IN_BITS  = 1,
  parameter int OUT_BITS = 2
);
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic                   display_on;
  logic                   frame_start;
  logic [15:0]            frame_cnt;
  logic [3*IN_BITS-1:0]   game_rgb;
  logic                   hsync;
  logic                   vsync;
  logic [OUT_BITS-1:0]    red;
  logic [OUT_BITS-1:0]    green;
  logic [OUT_BITS-1:0]    blue;

  modport master (
    output x, y, display_on, frame_start, frame_cnt,
    output hsync, vsync, red, green, blue,
    input  game_rgb
  );

  modport slave (
    input  x, y, display_on, frame_start, frame_cnt,
    input  hsync, vsync, red, green, blue,
    output game_rgb
  );
endinterface

// File: rtl/vga_game_frontend.sv
// VGA timing, game-latency sync alignment, colour expansion and key debouncing.
// Optional colour-bar generator: define VGA_GAME_TEST_PATTERN_EN.
module vga_game_frontend #(
  parameter int H_VIS           = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_VIS           = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int GAME_LATENCY    = 1,
  parameter int IN_BITS         = 1,
  parameter int OUT_BITS        = 2,
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] keys_raw,
  output logic [N_KEYS-1:0] keys,
  output logic [N_KEYS-1:0] keys_pressed,
  output logic              launch,
`ifdef VGA_GAME_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  vga_game_if.master        vga
);

  localparam int   H_TOTAL    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int   XW         = $clog2(H_TOTAL);
  localparam int   YW         = $clog2(V_TOTAL);
  localparam int   H_SYNC_BEG = H_VIS + H_FP;
  localparam int   V_SYNC_BEG = V_VIS + V_FP;
  localparam logic SYNC_INV   = (SYNC_ACTIVE_LOW != 0);

  // Per-pixel control that must travel alongside the game's colour latency.
  typedef struct packed {
    logic h;
    logic v;
    logic de;
`ifdef VGA_GAME_TEST_PATTERN_EN
    logic       tm;
    logic [2:0] bar;
`endif
  } pix_t;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [15:0]   frame_cnt_q;
  logic          x_last, y_last, frame_start, display_on;

  assign x_last      = (int'(x_q) == H_TOTAL - 1);
  assign y_last      = (int'(y_q) == V_TOTAL - 1);
  assign frame_start = (x_q == '0) && (y_q == '0);
  assign display_on  = (int'(x_q) < H_VIS) && (int'(y_q) < V_VIS);

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking = here would let later statements see already-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      x_q <= x_last ? '0 : x_q + 1'b1;
      if (x_last) y_q <= y_last ? '0 : y_q + 1'b1;
      if (frame_start) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.display_on  = display_on;
  assign vga.frame_start = frame_start;
  assign vga.frame_cnt   = frame_cnt_q;

  pix_t pix_raw, pix_d;

  // NOTE: always_comb assigns every output a default first so no path
  // leaves a value held, which would infer a latch.
  always_comb begin
    pix_raw    = '0;
    pix_raw.h  = (int'(x_q) >= H_SYNC_BEG) && (int'(x_q) < H_SYNC_BEG + H_SYNC);
    pix_raw.v  = (int'(y_q) >= V_SYNC_BEG) && (int'(y_q) < V_SYNC_BEG + V_SYNC);
    pix_raw.de = display_on;
`ifdef VGA_GAME_TEST_PATTERN_EN
    pix_raw.tm  = test_mode;
    pix_raw.bar = 3'(int'(x_q) / (H_VIS / 8));
`endif
  end

  if (GAME_LATENCY == 0) begin : g_no_dly
    assign pix_d = pix_raw;
  end else begin : g_dly
    pix_t dly [GAME_LATENCY];

    // NOTE: this short delay line is reset (unlike a RAM) so the pins show
    // inactive sync and blank colour until real timing has propagated.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < GAME_LATENCY; i++) dly[i] <= '0;
      end else begin
        dly[0] <= pix_raw;
        for (int i = 1; i < GAME_LATENCY; i++) dly[i] <= dly[i-1];
      end
    end

    assign pix_d = dly[GAME_LATENCY-1];
  end

  // Bit-replicate MSB-first, truncated to the DAC width (ab -> aba...).
  function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
    logic [OUT_BITS-1:0] e;
    for (int i = 0; i < OUT_BITS; i++) e[OUT_BITS-1-i] = c[IN_BITS-1-(i % IN_BITS)];
    return e;
  endfunction

  logic [OUT_BITS-1:0] r_nx, g_nx, b_nx;

  always_comb begin
    r_nx = '0;
    g_nx = '0;
    b_nx = '0;
    if (pix_d.de) begin
`ifdef VGA_GAME_TEST_PATTERN_EN
      if (pix_d.tm) begin
        r_nx = {OUT_BITS{pix_d.bar[2]}};
        g_nx = {OUT_BITS{pix_d.bar[1]}};
        b_nx = {OUT_BITS{pix_d.bar[0]}};
      end else
`endif
      begin
        r_nx = expand(vga.game_rgb[3*IN_BITS-1 -: IN_BITS]);
        g_nx = expand(vga.game_rgb[2*IN_BITS-1 -: IN_BITS]);
        b_nx = expand(vga.game_rgb[IN_BITS-1:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.hsync <= SYNC_INV;
      vga.vsync <= SYNC_INV;
      vga.red   <= '0;
      vga.green <= '0;
      vga.blue  <= '0;
    end else begin
      vga.hsync <= pix_d.h ^ SYNC_INV;
      vga.vsync <= pix_d.v ^ SYNC_INV;
      vga.red   <= r_nx;
      vga.green <= g_nx;
      vga.blue  <= b_nx;
    end
  end

  logic [N_KEYS-1:0]     key_s1, key_s2, key_tc, key_rise;
  logic [DEBOUNCE_W-1:0] key_cnt [N_KEYS];

  // A key flips only after its synchronised level has differed for 2^DEBOUNCE_W clocks.
  always_comb begin
    key_tc = '0;
    for (int i = 0; i < N_KEYS; i++)
      key_tc[i] = (key_s2[i] != keys[i]) && (key_cnt[i] == '1);
    key_rise = key_tc & ~keys;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1       <= '0;
      key_s2       <= '0;
      keys         <= '0;
      keys_pressed <= '0;
      launch       <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) key_cnt[i] <= '0;
    end else begin
      key_s1 <= keys_raw;
      key_s2 <= key_s1;
      for (int i = 0; i < N_KEYS; i++) begin
        if ((key_s2[i] == keys[i]) || key_tc[i]) key_cnt[i] <= '0;
        else                                     key_cnt[i] <= key_cnt[i] + 1'b1;
      end
      keys         <= keys ^ key_tc;
      keys_pressed <= key_rise;
      launch       <= |key_rise;
    end
  end

endmodule

// File: tb/tb_vga_game_frontend.sv
// Directed bench for vga_game_frontend on a shrunken 24x12 raster, latency 3.
module tb_vga_game_frontend;

  localparam int HV = 16, HFP = 2, HS = 3, HBP = 3, HT = 24;
  localparam int VV = 8,  VFP = 1, VS = 2, VBP = 1, VT = 12;
  localparam int LAT = 3, DBW = 4, FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] keys_raw = 2'b00;
  logic [1:0] keys, keys_pressed;
  logic       launch;
`ifdef VGA_GAME_TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif

  vga_game_if #(.XW(5), .YW(4), .IN_BITS(1), .OUT_BITS(2)) vga ();

  vga_game_frontend #(
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_ACTIVE_LOW(1), .GAME_LATENCY(LAT), .IN_BITS(1), .OUT_BITS(2),
    .N_KEYS(2), .DEBOUNCE_W(DBW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .keys_raw     (keys_raw),
    .keys         (keys),
    .keys_pressed (keys_pressed),
    .launch       (launch),
`ifdef VGA_GAME_TEST_PATTERN_EN
    .test_mode    (test_mode),
`endif
    .vga          (vga)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] g_hist  [1024];
  logic       tm_hist [1024];
  logic [5:0] rgb_obs;

  assign rgb_obs = {vga.red, vga.green, vga.blue};

  function automatic int xm(input int c); return c % HT; endfunction
  function automatic int ym(input int c); return (c / HT) % VT; endfunction
  function automatic logic de(input int c); return (xm(c) < HV) && (ym(c) < VV); endfunction

  function automatic logic exp_hs(input int c);
    int k;
    if (c < LAT + 1) return 1'b1;
    k = xm(c - LAT - 1);
    return !((k >= HV + HFP) && (k < HV + HFP + HS));
  endfunction

  function automatic logic exp_vs(input int c);
    int k;
    if (c < LAT + 1) return 1'b1;
    k = ym(c - LAT - 1);
    return !((k >= VV + VFP) && (k < VV + VFP + VS));
  endfunction

  // Pins at cycle c show the pixel scanned at c-LAT-1 with game colour sampled at c-1.
  function automatic logic [5:0] exp_rgb(input int c);
    int k;
    logic [2:0] b;
    if (c < LAT + 1) return 6'b0;
    k = c - LAT - 1;
    if (!de(k)) return 6'b0;
    b = tm_hist[k] ? 3'(xm(k) / (HV / 8)) : g_hist[c-1];
    return {b[2], b[2], b[1], b[1], b[0], b[0]};
  endfunction

  task automatic apply_reset();
    for (int i = 0; i < 1024; i++) begin
      g_hist[i]  = 3'b000;
      tm_hist[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vga.game_rgb = 3'b111;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (vga.x !== 5'd0 || vga.y !== 4'd0 || vga.frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: x=%0d y=%0d frame_cnt=%0d, required 0 0 0", vga.x, vga.y, vga.frame_cnt);
    end
    n_tests++;
    if (vga.hsync !== 1'b1 || vga.vsync !== 1'b1 || rgb_obs !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_pins: hs=%b vs=%b rgb=%b, required 1 1 000000", vga.hsync, vga.vsync, rgb_obs);
    end
    n_tests++;
    if (keys !== 2'b00 || keys_pressed !== 2'b00 || launch !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_keys: keys=%b pressed=%b launch=%b, required 00 00 0", keys, keys_pressed, launch);
    end
  endtask

  task automatic test_timing();
    logic [2:0] g;
    apply_reset();
    for (int c = 0; c < 2 * FRAME; c++) begin
      g = (c >= LAT) ? 3'(xm(c - LAT)) : 3'b000;
      vga.game_rgb = g;
      g_hist[c] = g;
      n_tests++;
      if (vga.x !== 5'(xm(c)) || vga.y !== 4'(ym(c)) || vga.display_on !== de(c) ||
          vga.frame_start !== (xm(c) == 0 && ym(c) == 0) ||
          vga.frame_cnt !== 16'((c + FRAME - 1) / FRAME)) begin
        n_fail++;
        $display("FAIL timing_pos c=%0d: x=%0d y=%0d de=%b fs=%b fc=%0d, required %0d %0d %b %b %0d",
                 c, vga.x, vga.y, vga.display_on, vga.frame_start, vga.frame_cnt,
                 xm(c), ym(c), de(c), (xm(c) == 0 && ym(c) == 0), (c + FRAME - 1) / FRAME);
      end
      n_tests++;
      if (vga.hsync !== exp_hs(c) || vga.vsync !== exp_vs(c) || rgb_obs !== exp_rgb(c)) begin
        n_fail++;
        $display("FAIL timing_pins c=%0d: hs=%b vs=%b rgb=%b, required %b %b %b",
                 c, vga.hsync, vga.vsync, rgb_obs, exp_hs(c), exp_vs(c), exp_rgb(c));
      end
      @(negedge clk);
      #1;
    end
    n_tests++;
    if (vga.frame_cnt !== 16'd2 || vga.frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_cnt_two_frames: fc=%0d fs=%b, required 2 1", vga.frame_cnt, vga.frame_start);
    end
  endtask

  task automatic test_const_colour();
    apply_reset();
    vga.game_rgb = 3'b101;
    for (int c = 0; c < 2 * HT; c++) begin
      g_hist[c] = 3'b101;
      n_tests++;
      if (rgb_obs !== exp_rgb(c) || vga.hsync !== exp_hs(c)) begin
        n_fail++;
        $display("FAIL const_colour c=%0d: rgb=%b hs=%b, required %b %b", c, rgb_obs, vga.hsync, exp_rgb(c), exp_hs(c));
      end
      if (c == LAT + 1) begin
        n_tests++;
        if (rgb_obs !== 6'b110011) begin
          n_fail++;
          $display("FAIL const_first_pixel: rgb=%b, required 110011", rgb_obs);
        end
      end
      if (c == LAT + 1 + HV) begin
        n_tests++;
        if (rgb_obs !== 6'b000000) begin
          n_fail++;
          $display("FAIL const_blank_edge: rgb=%b, required 000000", rgb_obs);
        end
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_keys_debounce();
    int pulses = 0, launches = 0, rise_at = -1;
    logic early = 1'b0, pulse_at_rise = 1'b0;
    keys_raw = 2'b00;
    repeat (30) @(negedge clk);
    #1;
    repeat (3) begin
      keys_raw[0] = 1'b1;
      repeat (10) begin
        @(negedge clk); #1;
        if (keys[0]) early = 1'b1;
        if (keys_pressed[0]) pulses++;
        if (launch) launches++;
      end
      keys_raw[0] = 1'b0;
      @(negedge clk); #1;
    end
    n_tests++;
    if (early !== 1'b0 || pulses != 0) begin
      n_fail++;
      $display("FAIL key_glitch: accepted=%b pulses=%0d, required 0 0", early, pulses);
    end
    keys_raw[0] = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk); #1;
      if (keys_pressed[0]) pulses++;
      if (launch) launches++;
      if (keys[0] && rise_at < 0) begin
        rise_at = n;
        pulse_at_rise = keys_pressed[0];
      end
    end
    n_tests++;
    if (rise_at != 18 || pulse_at_rise !== 1'b1) begin
      n_fail++;
      $display("FAIL key_rise_time: edge=%0d pulse=%b, required 18 1", rise_at, pulse_at_rise);
    end
    n_tests++;
    if (pulses != 1 || launches != 1) begin
      n_fail++;
      $display("FAIL key_single_pulse: pulses=%0d launches=%0d, required 1 1", pulses, launches);
    end
    pulses = 0;
    launches = 0;
    keys_raw[0] = 1'b0;
    repeat (30) begin
      @(negedge clk); #1;
      if (keys_pressed != 2'b00) pulses++;
      if (launch) launches++;
    end
    n_tests++;
    if (pulses != 0 || launches != 0 || keys !== 2'b00) begin
      n_fail++;
      $display("FAIL key_release: pulses=%0d launches=%0d keys=%b, required 0 0 00", pulses, launches, keys);
    end
  endtask

  task automatic test_keys_simultaneous();
    int both = 0, partial = 0, launches = 0;
    keys_raw = 2'b11;
    repeat (30) begin
      @(negedge clk); #1;
      if (keys_pressed == 2'b11) both++;
      else if (keys_pressed != 2'b00) partial++;
      if (launch) launches++;
    end
    n_tests++;
    if (both != 1 || partial != 0 || launches != 1 || keys !== 2'b11) begin
      n_fail++;
      $display("FAIL keys_together: both=%0d partial=%0d launches=%0d keys=%b, required 1 0 1 11",
               both, partial, launches, keys);
    end
    keys_raw = 2'b00;
    repeat (30) @(negedge clk);
    #1;
    n_tests++;
    if (keys !== 2'b00) begin
      n_fail++;
      $display("FAIL keys_together_release: keys=%b, required 00", keys);
    end
  endtask

  task automatic test_mid_reset();
    logic found = 1'b0;
    apply_reset();
    vga.game_rgb = 3'b111;
    keys_raw = 2'b11;
    for (int c = 0; c < 400; c++) begin
      if (vga.x == 5'd10 && vga.y == 4'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    n_tests++;
    if (!found || rgb_obs !== 6'b111111 || keys !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_reset_setup: reached=%b rgb=%b keys=%b, required 1 111111 11", found, rgb_obs, keys);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (vga.x !== 5'd0 || vga.y !== 4'd0 || vga.frame_cnt !== 16'd0 || vga.hsync !== 1'b1 ||
        vga.vsync !== 1'b1 || rgb_obs !== 6'b0 || keys !== 2'b00 || launch !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: x=%0d y=%0d fc=%0d hs=%b vs=%b rgb=%b keys=%b launch=%b, required 0 0 0 1 1 000000 00 0",
               vga.x, vga.y, vga.frame_cnt, vga.hsync, vga.vsync, rgb_obs, keys, launch);
    end
    repeat (5) @(negedge clk);
    keys_raw = 2'b00;
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (vga.x !== 5'd0 || vga.y !== 4'd0 || vga.frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_restart: x=%0d y=%0d fs=%b, required 0 0 1", vga.x, vga.y, vga.frame_start);
    end
    @(negedge clk); #1;
    n_tests++;
    if (vga.x !== 5'd1 || vga.frame_start !== 1'b0 || vga.frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL mid_reset_first_step: x=%0d fs=%b fc=%0d, required 1 0 1", vga.x, vga.frame_start, vga.frame_cnt);
    end
  endtask

`ifdef VGA_GAME_TEST_PATTERN_EN
  task automatic test_pattern();
    test_mode = 1'b1;
    apply_reset();
    vga.game_rgb = 3'b010;
    for (int c = 0; c < 3 * HT; c++) begin
      if (c == HT + 10) test_mode = 1'b0;
      tm_hist[c] = test_mode;
      g_hist[c]  = 3'b010;
      n_tests++;
      if (rgb_obs !== exp_rgb(c)) begin
        n_fail++;
        $display("FAIL pattern c=%0d: rgb=%b, required %b", c, rgb_obs, exp_rgb(c));
      end
      if (c == LAT + 1 || c == LAT + 15 || c == LAT + HT + 10 || c == LAT + HT + 11) begin
        n_tests++;
        if (rgb_obs !== (c == LAT + 1      ? 6'b000000 :
                         c == LAT + 15     ? 6'b111111 :
                         c == LAT + HT + 10 ? 6'b110000 : 6'b001100)) begin
          n_fail++;
          $display("FAIL pattern_hand c=%0d: rgb=%b", c, rgb_obs);
        end
      end
      @(negedge clk); #1;
    end
    test_mode = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    vga.game_rgb = 3'b000;
    test_reset();
    test_timing();
    test_const_colour();
    test_keys_debounce();
    test_keys_simultaneous();
    test_mid_reset();
`ifdef VGA_GAME_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
